// File: rtl/led_matrix_pkg.sv
// Shared geometry defaults, derived-size helpers and controller state type
// for the LED matrix frame store.
package led_matrix_pkg;

  localparam int COLS_DEF     = 64;
  localparam int ROWS_DEF     = 32;
  localparam int BPP_DEF      = 4;
  localparam int WR_WIDTH_DEF = 32;

  function automatic int calc_ppw(input int wr_width, input int bpp);
    return wr_width / bpp;
  endfunction

  // Words per half-matrix bank.
  function automatic int calc_depth(input int cols, input int rows,
                                    input int wr_width, input int bpp);
    return (cols * rows / 2) / calc_ppw(wr_width, bpp);
  endfunction

  typedef enum logic {
    FB_IDLE  = 1'b0,
    FB_CLEAR = 1'b1
  } fb_state_t;

endpackage

// File: rtl/pixel_frame_buffer_sdp_ram.sv
// Simple dual-port half-matrix RAM: word-wide write port, registered
// pixel-wide read port. Address MSB selects the bank on both ports.
module sdp_ram #(
  parameter  int WR_WIDTH = 32,
  parameter  int BPP      = 4,
  parameter  int DEPTH    = 128,
  localparam int PPW      = WR_WIDTH / BPP,
  localparam int WAW      = $clog2(DEPTH),
  localparam int RAW      = $clog2(DEPTH * PPW),
  localparam int LAW      = (PPW > 1) ? $clog2(PPW) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [WAW:0]        waddr,
  input  logic [WR_WIDTH-1:0] wdata,
  input  logic [RAW:0]        raddr,
  output logic [BPP-1:0]      dout
);

  logic [WR_WIDTH-1:0] mem [2*DEPTH];
  logic [WAW-1:0]      rd_word;
  logic [LAW-1:0]      rd_lane;
  logic [WR_WIDTH-1:0] rd_data;

  always_comb begin
    rd_word = WAW'(raddr[RAW-1:0] / PPW);
    rd_lane = LAW'(raddr[RAW-1:0] % PPW);
    rd_data = mem[{raddr[RAW], rd_word}];
  end

  // Contents are deliberately left unreset; software clears explicitly.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) dout <= '0;
    else      dout <= rd_data[rd_lane*BPP +: BPP];
  end

endmodule

// File: rtl/pixel_frame_buffer.sv
// Double-buffered LED matrix frame store with back-bank clear engine and
// frame-synchronous front/back swap.
//   state    | meaning
//   FB_IDLE  | back bank writable, swap may fire on frame_done
//   FB_CLEAR | clear engine filling back bank, writes dropped, swap deferred
module pixel_frame_buffer
  import led_matrix_pkg::*;
#(
  parameter  int             COLS      = COLS_DEF,
  parameter  int             ROWS      = ROWS_DEF,
  parameter  int             BPP       = BPP_DEF,
  parameter  int             WR_WIDTH  = WR_WIDTH_DEF,
  parameter  logic [BPP-1:0] CLEAR_PIX = '0,
  localparam int             PPW       = calc_ppw(WR_WIDTH, BPP),
  localparam int             HPIX      = COLS * ROWS / 2,
  localparam int             DEPTH     = calc_depth(COLS, ROWS, WR_WIDTH, BPP),
  localparam int             RAW       = $clog2(HPIX),
  localparam int             WAW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RAW-1:0]      rdaddr_pix_upper,
  output logic [BPP-1:0]      dout_pix_upper,
  input  logic [RAW-1:0]      rdaddr_pix_lower,
  output logic [BPP-1:0]      dout_pix_lower,
  input  logic                we,
  input  logic                wr_half,
  input  logic [WAW-1:0]      wraddr_col,
  input  logic [WR_WIDTH-1:0] din_col,
  output logic                wr_ready,
  input  logic                clear_req,
  output logic                busy,
  input  logic                swap_req,
  input  logic                frame_done,
  output logic                swap_pending,
  output logic                swap_done,
  output logic                front_sel
);

  fb_state_t           state, state_nxt;
  logic [WAW-1:0]      clr_cnt;
  logic                clr_last;
  logic                swap_fire;
  logic                wr_ok;
  logic                we_upper, we_lower;
  logic [WAW:0]        ram_waddr;
  logic [WR_WIDTH-1:0] ram_wdata;

  assign clr_last = (clr_cnt == WAW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= FB_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FB_IDLE:  if (clear_req) state_nxt = FB_CLEAR;
      FB_CLEAR: if (clr_last)  state_nxt = FB_IDLE;
      default:  state_nxt = FB_IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (state == FB_IDLE);
    busy     = (state == FB_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!rst || state != FB_CLEAR) clr_cnt <= '0;
    else                           clr_cnt <= clr_cnt + 1'b1;
  end

  // A request arriving in the firing cycle stays pending for the next frame.
  assign swap_fire = swap_pending && frame_done && (state == FB_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      front_sel    <= front_sel ^ swap_fire;
      swap_pending <= swap_req | (swap_pending & ~swap_fire);
      swap_done    <= swap_fire;
    end
  end

  always_comb begin
    wr_ok     = we && wr_ready;
    we_upper  = busy || (wr_ok && !wr_half);
    we_lower  = busy || (wr_ok &&  wr_half);
    ram_waddr = {~front_sel, (busy ? clr_cnt : wraddr_col)};
    ram_wdata = busy ? {PPW{CLEAR_PIX}} : din_col;
  end

  sdp_ram #(.WR_WIDTH(WR_WIDTH), .BPP(BPP), .DEPTH(DEPTH)) u_ram_upper (
    .clk   (clk),
    .rst   (rst),
    .we    (we_upper),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr ({front_sel, rdaddr_pix_upper}),
    .dout  (dout_pix_upper)
  );

  sdp_ram #(.WR_WIDTH(WR_WIDTH), .BPP(BPP), .DEPTH(DEPTH)) u_ram_lower (
    .clk   (clk),
    .rst   (rst),
    .we    (we_lower),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr ({front_sel, rdaddr_pix_lower}),
    .dout  (dout_pix_lower)
  );

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Self-checking bench for pixel_frame_buffer: pixel-array reference model
// compared every cycle, plus directed literal expectations.
module tb_pixel_frame_buffer;

  localparam int COLS      = 64;
  localparam int ROWS      = 32;
  localparam int BPP       = 4;
  localparam int WR_WIDTH  = 32;
  localparam int PPW       = WR_WIDTH / BPP;
  localparam int HPIX      = COLS * ROWS / 2;
  localparam int DEPTH     = HPIX / PPW;
  localparam int RAW       = $clog2(HPIX);
  localparam int WAW       = $clog2(DEPTH);
  localparam int CLEAR_PIX = 0;

  logic                clk;
  logic                rst;
  logic [RAW-1:0]      rdaddr_pix_upper, rdaddr_pix_lower;
  logic [BPP-1:0]      dout_pix_upper, dout_pix_lower;
  logic                we, wr_half;
  logic [WAW-1:0]      wraddr_col;
  logic [WR_WIDTH-1:0] din_col;
  logic                wr_ready, clear_req, busy;
  logic                swap_req, frame_done, swap_pending, swap_done, front_sel;

  pixel_frame_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .rdaddr_pix_upper (rdaddr_pix_upper),
    .dout_pix_upper   (dout_pix_upper),
    .rdaddr_pix_lower (rdaddr_pix_lower),
    .dout_pix_lower   (dout_pix_lower),
    .we               (we),
    .wr_half          (wr_half),
    .wraddr_col       (wraddr_col),
    .din_col          (din_col),
    .wr_ready         (wr_ready),
    .clear_req        (clear_req),
    .busy             (busy),
    .swap_req         (swap_req),
    .frame_done       (frame_done),
    .swap_pending     (swap_pending),
    .swap_done        (swap_done),
    .front_sel        (front_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-pixel contents of [half][bank], plus swap/clear bookkeeping.
  int  m_pix [2][2][HPIX];
  bit  m_ok  [2][2][HPIX];
  int  m_busy_left = 0, m_clr_word = 0;
  bit  m_front = 0, m_pending = 0, m_swap_done = 0;
  int  m_dout_u = 0, m_dout_l = 0;
  bit  m_ok_u = 1, m_ok_l = 1;
  bit  chk_en = 0;

  always @(posedge clk) begin
    bit busy_now, fire;
    int bk;
    if (!rst) begin
      m_busy_left = 0; m_front = 0; m_pending = 0; m_swap_done = 0;
      m_dout_u = 0; m_dout_l = 0; m_ok_u = 1; m_ok_l = 1;
    end else begin
      m_dout_u = m_pix[0][m_front][rdaddr_pix_upper];
      m_ok_u   = m_ok [0][m_front][rdaddr_pix_upper];
      m_dout_l = m_pix[1][m_front][rdaddr_pix_lower];
      m_ok_l   = m_ok [1][m_front][rdaddr_pix_lower];
      busy_now = (m_busy_left > 0);
      bk = m_front ? 0 : 1;
      if (busy_now) begin
        for (int h = 0; h < 2; h++)
          for (int k = 0; k < PPW; k++) begin
            m_pix[h][bk][m_clr_word*PPW + k] = CLEAR_PIX;
            m_ok [h][bk][m_clr_word*PPW + k] = 1'b1;
          end
        m_clr_word++;
        m_busy_left--;
      end else begin
        if (we)
          for (int k = 0; k < PPW; k++) begin
            m_pix[wr_half][bk][int'(wraddr_col)*PPW + k] = int'(din_col[k*BPP +: BPP]);
            m_ok [wr_half][bk][int'(wraddr_col)*PPW + k] = 1'b1;
          end
        if (clear_req) begin
          m_busy_left = DEPTH;
          m_clr_word  = 0;
        end
      end
      fire = m_pending && frame_done && !busy_now;
      if (fire) m_front = !m_front;
      m_swap_done = fire;
      m_pending   = swap_req || (m_pending && !fire);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",         busy,         m_busy_left > 0);
      check("wr_ready",     wr_ready,     !(m_busy_left > 0));
      check("swap_pending", swap_pending, m_pending);
      check("swap_done",    swap_done,    m_swap_done);
      check("front_sel",    front_sel,    m_front);
      if (m_ok_u) check("dout_upper", dout_pix_upper, m_dout_u);
      if (m_ok_l) check("dout_lower", dout_pix_lower, m_dout_l);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      rdaddr_pix_upper = RAW'($urandom_range(0, HPIX - 1));
      rdaddr_pix_lower = RAW'($urandom_range(0, HPIX - 1));
      cyc();
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1; cyc(); clear_req = 1'b0;
  endtask

  task automatic do_swap(input logic exp_front);
    swap_req = 1'b1; cyc(); swap_req = 1'b0;
    frame_done = 1'b1; cyc(); frame_done = 1'b0;
    check("swap_done_lit", swap_done, 1);
    check("front_after_swap", front_sel, exp_front);
  endtask

  task automatic write_word(input logic half, input int addr, input logic [31:0] data);
    we = 1'b1; wr_half = half; wraddr_col = WAW'(addr); din_col = data;
    cyc();
    we = 1'b0;
  endtask

  task automatic read_chk(input string name, input int ua, input int la,
                          input int exp_u, input int exp_l);
    rdaddr_pix_upper = RAW'(ua);
    rdaddr_pix_lower = RAW'(la);
    cyc();
    check({name, "_u"}, dout_pix_upper, exp_u);
    check({name, "_l"}, dout_pix_lower, exp_l);
  endtask

  initial begin
    int n;
    rst = 1'b0; we = 1'b0; wr_half = 1'b0; wraddr_col = '0; din_col = '0;
    clear_req = 1'b0; swap_req = 1'b0; frame_done = 1'b0;
    rdaddr_pix_upper = '0; rdaddr_pix_lower = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_front", front_sel, 0);
    check("rst_pending", swap_pending, 0);
    check("rst_swap_done", swap_done, 0);
    check("rst_dout_u", dout_pix_upper, 0);
    check("rst_dout_l", dout_pix_lower, 0);
    rst = 1'b1;

    // Clear back bank 1 and measure busy window.
    pulse_clear();
    n = 0;
    while (busy === 1'b1 && n < 300) begin cyc(); n++; end
    check("clear_len", n, DEPTH);

    swap_req = 1'b1; cyc(); swap_req = 1'b0;
    check("pending_set", swap_pending, 1);
    frame_done = 1'b1; cyc(); frame_done = 1'b0;
    check("swap_done_first", swap_done, 1);
    check("front_first", front_sel, 1);
    read_chk("cleared_a", 0, 777, 0, 0);
    read_chk("cleared_b", 1023, 512, 0, 0);

    // Clear bank 0, write lower word 5, swap it to the front.
    pulse_clear();
    wait_idle("idle_timeout_1");
    write_word(1'b1, 5, 32'h8765_4321);
    do_swap(1'b0);
    for (int i = 0; i < 8; i++) read_chk("lane", 40, 40 + i, 0, i + 1);

    // Back-bank write invisible until swap; second swap restores old view.
    write_word(1'b0, 3, 32'hA5A5_A5A5);
    read_chk("noswap", 24, 40, 0, 1);
    do_swap(1'b1);
    read_chk("swapped_a", 24, 40, 5, 0);
    read_chk("swapped_b", 25, 41, 10, 0);
    do_swap(1'b0);
    read_chk("swapback", 24, 40, 0, 1);

    // Write during clear is dropped.
    pulse_clear();
    repeat (10) cyc();
    check("wr_ready_in_clear", wr_ready, 0);
    write_word(1'b0, 3, 32'hFFFF_FFFF);
    wait_idle("idle_timeout_2");
    do_swap(1'b1);
    read_chk("dropped_a", 24, 40, CLEAR_PIX, CLEAR_PIX);
    read_chk("dropped_b", 31, 47, CLEAR_PIX, CLEAR_PIX);

    // frame_done during clear defers the swap.
    swap_req = 1'b1; cyc(); swap_req = 1'b0;
    pulse_clear();
    repeat (5) cyc();
    frame_done = 1'b1; cyc(); frame_done = 1'b0;
    check("defer_swap_done", swap_done, 0);
    check("defer_front", front_sel, 1);
    check("defer_pending", swap_pending, 1);
    wait_idle("idle_timeout_3");
    frame_done = 1'b1; cyc(); frame_done = 1'b0;
    check("deferred_done", swap_done, 1);
    check("deferred_front", front_sel, 0);
    check("deferred_pending", swap_pending, 0);

    // New request coinciding with the swap trigger stays pending.
    swap_req = 1'b1; cyc();
    frame_done = 1'b1; cyc();
    swap_req = 1'b0; frame_done = 1'b0;
    check("overlap_front", front_sel, 1);
    check("overlap_pending", swap_pending, 1);
    frame_done = 1'b1; cyc(); frame_done = 1'b0;
    check("overlap2_front", front_sel, 0);
    check("overlap2_pending", swap_pending, 0);

    // Reset at clear cycle 50 aborts clear and discards the pending swap.
    do_swap(1'b1);
    swap_req = 1'b1; cyc(); swap_req = 1'b0;
    pulse_clear();
    repeat (49) cyc();
    check("mid_clear_busy", busy, 1);
    rst = 1'b0; cyc(); rst = 1'b1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_front", front_sel, 0);
    check("rst_mid_pending", swap_pending, 0);
    check("rst_mid_wr_ready", wr_ready, 1);
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
